// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - core load/store and data-memory port bundle for dcache_dm
// DCACHE_STATS_EN adds the hit/miss counter outputs.
interface dcache_dm_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 i_rd;
  logic                 i_wr;
  logic [BUS_WIDTH-1:0] i_addr;
  logic [BUS_WIDTH-1:0] i_wdata;
  logic [BUS_WIDTH-1:0] o_rdata;
  logic                 o_stall;
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [BUS_WIDTH-1:0] o_mem_addr;
  logic [BUS_WIDTH-1:0] o_mem_wdata;
  logic                 i_mem_ack;
  logic [BUS_WIDTH-1:0] i_mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]          o_hit_cnt;
  logic [31:0]          o_miss_cnt;
`endif

  modport master (
    output i_rd, i_wr, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    input  o_rdata, o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
`ifdef DCACHE_STATS_EN
    , o_hit_cnt, o_miss_cnt
`endif
  );

  modport slave (
    input  i_rd, i_wr, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    output o_rdata, o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
`ifdef DCACHE_STATS_EN
    , o_hit_cnt, o_miss_cnt
`endif
  );
endinterface

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped, write-through, no-write-allocate one-word-line data cache
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_dm #(
  parameter int BUS_WIDTH  = 32,
  parameter int INDEX_BITS = 6
) (
  input logic        i_clk,
  input logic        i_rst,
  dcache_dm_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = BUS_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RFILL, WTHRU} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tags [LINES];
  logic [BUS_WIDTH-1:0] data [LINES];

  logic                 mem_req;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      atag;
  logic [BUS_WIDTH-1:0]  aligned_addr;
  logic                  hit;
  logic                  rd_hit;
  logic                  unused_addr_lsbs;

  assign idx              = bus.i_addr[INDEX_BITS+1:2];
  assign atag             = bus.i_addr[BUS_WIDTH-1:INDEX_BITS+2];
  assign aligned_addr     = {bus.i_addr[BUS_WIDTH-1:2], 2'b00};
  assign unused_addr_lsbs = ^bus.i_addr[1:0];
  assign hit              = valid[idx] && (tags[idx] == atag);
  // A simultaneous store wins, so a load paired with a store is never a hit.
  assign rd_hit           = (state == IDLE) && bus.i_rd && !bus.i_wr && hit;

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  assign bus.o_hit_cnt  = hit_cnt;
  assign bus.o_miss_cnt = miss_cnt;
`endif

  always_comb begin
    bus.o_stall = 1'b0;
    bus.o_rdata = '0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          bus.o_stall = bus.i_wr | (bus.i_rd & ~hit);
          if (rd_hit) bus.o_rdata = data[idx];
        end
        RFILL: begin
          bus.o_stall = ~bus.i_mem_ack;
          // Fill data is forwarded so the core can advance on the ack edge.
          if (bus.i_mem_ack) bus.o_rdata = bus.i_mem_rdata;
        end
        WTHRU: bus.o_stall = ~bus.i_mem_ack;
        default: bus.o_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DCACHE_STATS_EN
      hit_cnt   <= '0;
      miss_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_wr) begin
            state     <= WTHRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= aligned_addr;
            mem_wdata <= bus.i_wdata;
          end else if (bus.i_rd && !hit) begin
            state    <= RFILL;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= aligned_addr;
`ifdef DCACHE_STATS_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
          end else if (rd_hit) begin
`ifdef DCACHE_STATS_EN
            hit_cnt <= hit_cnt + 32'd1;
`endif
          end
        end
        RFILL: begin
          if (bus.i_mem_ack) begin
            valid[idx] <= 1'b1;
            tags[idx]  <= atag;
            data[idx]  <= bus.i_mem_rdata;
            mem_req    <= 1'b0;
            state      <= IDLE;
          end
        end
        WTHRU: begin
          if (bus.i_mem_ack) begin
            // No allocate on a store miss; a hit keeps the line coherent with memory.
            if (hit) data[idx] <= bus.i_wdata;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
